// File: rtl/rv32i_types.sv
// ============================================================================
// rv32i_types: shared RV32I pipeline types and the hazard controller state.
// Revision: 1.0
// ============================================================================
`default_nettype none

package rv32i_types;

  typedef logic [4:0] rv32i_reg;

  typedef struct packed {
    logic load_regfile;
    logic mem_read;
    logic mem_write;
  } rv32i_control_word;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

  // Saturating increment shared by the performance counters.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
    sat_inc = (value == max_value) ? value : value + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_perf_counters.sv
// ============================================================================
// hazard_perf_counters: saturating memory-stall, load-use and flush counters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_perf_counters
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_stall,
  input  logic             lu_bubble,
  input  logic             redirect,
  output logic [CNT_W-1:0] stall_mem_cnt,
  output logic [CNT_W-1:0] stall_lu_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? {64{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_mem_cnt <= '0;
      stall_lu_cnt  <= '0;
      flush_cnt     <= '0;
    end else begin
      if (mem_stall) stall_mem_cnt <= CNT_W'(sat_inc(64'(stall_mem_cnt), CNT_MAX));
      if (lu_bubble) stall_lu_cnt  <= CNT_W'(sat_inc(64'(stall_lu_cnt), CNT_MAX));
      if (redirect)  flush_cnt     <= CNT_W'(sat_inc(64'(flush_cnt), CNT_MAX));
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_control.sv
// ============================================================================
// hazard_control: pipeline stall/flush controller for the 5-stage RV32I core.
// Optional counters enabled by defining HAZARD_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_control
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_reg          if_id_rs1_out,
  input  rv32i_reg          if_id_rs2_out,
  input  rv32i_reg          id_ex_rd_out,
  input  rv32i_control_word id_ex_ctrl_out,
  input  rv32i_control_word ex_mem_ctrl_out,
  input  logic              br_taken_ex,
  input  logic              icache_read,
  input  logic              icache_resp,
  input  logic              dcache_resp,
  output logic              load_pc,
  output logic              load_if_id,
  output logic              load_id_ex,
  output logic              load_ex_mem,
  output logic              load_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              imem_capture,
  output logic              dmem_capture
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_mem_cnt,
  output logic [CNT_W-1:0]  stall_lu_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  hazard_state_t state;
  logic          i_done;
  logic          d_done;
  logic          dreq;
  logic          i_pend;
  logic          d_pend;
  logic          mem_busy;
  logic          load_use;
  logic          unused_ctrl;

  assign dreq     = ex_mem_ctrl_out.mem_read | ex_mem_ctrl_out.mem_write;
  assign i_pend   = icache_read & ~icache_resp & ~i_done;
  assign d_pend   = dreq & ~dcache_resp & ~d_done;
  assign mem_busy = i_pend | d_pend;
  assign load_use = id_ex_ctrl_out.mem_read & id_ex_ctrl_out.load_regfile &
                    (id_ex_rd_out != 5'd0) &
                    ((id_ex_rd_out == if_id_rs1_out) | (id_ex_rd_out == if_id_rs2_out));

  assign unused_ctrl = ^{id_ex_ctrl_out.mem_write, ex_mem_ctrl_out.load_regfile};

  // Done flags remember a response that beat the other side's response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (mem_busy) begin
      state <= MEM_WAIT;
      if (icache_resp) i_done <= 1'b1;
      if (dcache_resp) d_done <= 1'b1;
    end else if (state == MEM_WAIT) begin
      state  <= RUN;
      i_done <= 1'b0;
      d_done <= 1'b0;
    end
  end

  always_comb begin
    load_pc      = 1'b1;
    load_if_id   = 1'b1;
    load_id_ex   = 1'b1;
    load_ex_mem  = 1'b1;
    load_mem_wb  = 1'b1;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    imem_capture = icache_resp & ~rst;
    dmem_capture = dcache_resp & ~rst;
    if (rst || mem_busy) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      load_id_ex  = 1'b0;
      load_ex_mem = 1'b0;
      load_mem_wb = 1'b0;
      flush_if_id = rst;
      flush_id_ex = rst;
    end else if (br_taken_ex) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (load_use) begin
      load_pc     = 1'b0;
      load_if_id  = 1'b0;
      flush_id_ex = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk           (clk),
    .rst           (rst),
    .mem_stall     (mem_busy),
    .lu_bubble     (load_use & ~mem_busy & ~br_taken_ex),
    .redirect      (br_taken_ex & ~mem_busy),
    .stall_mem_cnt (stall_mem_cnt),
    .stall_lu_cnt  (stall_lu_cnt),
    .flush_cnt     (flush_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_control.sv
// ============================================================================
// tb_hazard_control: vector table, multi-cycle sequences and random checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_hazard_control;
  import rv32i_types::*;

  logic              clk = 1'b0;
  logic              rst;
  rv32i_reg          rs1, rs2, rd;
  rv32i_control_word idc, exc;
  logic              br, iread, iresp, dresp;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic flush_if_id, flush_id_ex, imem_capture, dmem_capture;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_mem_cnt, stall_lu_cnt, flush_cnt;
`endif

  hazard_control #(.CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_id_rs1_out   (rs1),
    .if_id_rs2_out   (rs2),
    .id_ex_rd_out    (rd),
    .id_ex_ctrl_out  (idc),
    .ex_mem_ctrl_out (exc),
    .br_taken_ex     (br),
    .icache_read     (iread),
    .icache_resp     (iresp),
    .dcache_resp     (dresp),
    .load_pc         (load_pc),
    .load_if_id      (load_if_id),
    .load_id_ex      (load_id_ex),
    .load_ex_mem     (load_ex_mem),
    .load_mem_wb     (load_mem_wb),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .imem_capture    (imem_capture),
    .dmem_capture    (dmem_capture)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_mem_cnt   (stall_mem_cnt),
    .stall_lu_cnt    (stall_lu_cnt),
    .flush_cnt       (flush_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: which responses of the current stalled episode have arrived.
  bit got_i = 1'b0;
  bit got_d = 1'b0;

  // Layout: {load pc,if_id,id_ex,ex_mem,mem_wb, flush if_id,id_ex, capture i,d}
  logic [8:0] dut_vec;
  assign dut_vec = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                    flush_if_id, flush_id_ex, imem_capture, dmem_capture};

  function automatic bit model_stall();
    bit waiting_i;
    bit waiting_d;
    waiting_i = iread && !iresp && !got_i;
    waiting_d = (exc.mem_read || exc.mem_write) && !dresp && !got_d;
    return waiting_i || waiting_d;
  endfunction

  function automatic logic [8:0] model_out();
    logic [1:0] cap;
    bit hazard;
    cap    = {iresp, dresp};
    hazard = idc.mem_read && idc.load_regfile && (rd != 0) && (rd == rs1 || rd == rs2);
    if (rst)           return 9'b00000_11_00;
    if (model_stall()) return {5'b00000, 2'b00, cap};
    if (br)            return {5'b11111, 2'b11, cap};
    if (hazard)        return {5'b00111, 2'b01, cap};
    return {5'b11111, 2'b00, cap};
  endfunction

  task automatic model_commit();
    if (rst) begin
      got_i = 1'b0;
      got_d = 1'b0;
    end else if (model_stall()) begin
      got_i = got_i || iresp;
      got_d = got_d || dresp;
    end else begin
      got_i = 1'b0;
      got_d = 1'b0;
    end
  endtask

  task automatic tick(input string name, input logic [8:0] exp);
    @(negedge clk);
    checks++;
    if (dut_vec !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, dut_vec, exp, $time);
    end
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    rst = 0; rs1 = 0; rs2 = 0; rd = 0; idc = '0; exc = '0;
    br = 0; iread = 0; iresp = 0; dresp = 0;
  endtask

  typedef struct {
    string      name;
    logic       rst;
    rv32i_reg   rs1, rs2, rd;
    logic       id_mr, id_lr, ex_mr, ex_mw, br, ird, irsp, drsp;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{"idle",          0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 0, 0, 0, 0, 9'b11111_00_00};
    vecs[1]  = '{"lu_rs1",        0, 5'd5, 5'd1, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 9'b00111_01_00};
    vecs[2]  = '{"lu_rs2",        0, 5'd1, 5'd7, 5'd7, 1, 1, 0, 0, 0, 0, 0, 0, 9'b00111_01_00};
    vecs[3]  = '{"lu_x0",         0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 0, 0, 0, 9'b11111_00_00};
    vecs[4]  = '{"lu_nomatch",    0, 5'd6, 5'd7, 5'd5, 1, 1, 0, 0, 0, 0, 0, 0, 9'b11111_00_00};
    vecs[5]  = '{"lu_no_wb",      0, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 0, 9'b11111_00_00};
    vecs[6]  = '{"redirect",      0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 9'b11111_11_00};
    vecs[7]  = '{"redirect_lu",   0, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 1, 0, 0, 0, 9'b11111_11_00};
    vecs[8]  = '{"imiss",         0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 9'b00000_00_00};
    vecs[9]  = '{"ihit",          0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 1, 0, 9'b11111_00_10};
    vecs[10] = '{"dmiss_load",    0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 0, 0, 0, 9'b00000_00_00};
    vecs[11] = '{"dhit_store",    0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 0, 0, 1, 9'b11111_00_01};
    vecs[12] = '{"redirect_stall",0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 1, 0, 0, 9'b00000_00_00};
    vecs[13] = '{"lu_stall",      0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 0, 0, 0, 0, 0, 9'b00000_00_00};
    vecs[14] = '{"reset_active",  1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, 1, 1, 1, 1, 9'b00000_11_00};
    vecs[15] = '{"dresp_run",     0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1, 9'b11111_00_01};
  end

  initial begin
    clear_in();
    rst = 1;
    @(posedge clk); #1;
    tick("reset_state", 9'b00000_11_00);
    rst = 0;
    tick("first_after_reset", 9'b11111_00_00);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
      idc = '{load_regfile: vecs[i].id_lr, mem_read: vecs[i].id_mr, mem_write: 1'b0};
      exc = '{load_regfile: 1'b0, mem_read: vecs[i].ex_mr, mem_write: vecs[i].ex_mw};
      br = vecs[i].br; iread = vecs[i].ird; iresp = vecs[i].irsp; dresp = vecs[i].drsp;
      tick(vecs[i].name, vecs[i].exp);
    end
    clear_in();

    // Four-cycle I-miss
    iread = 1;
    for (int i = 0; i < 4; i++) tick("imiss_wait", 9'b00000_00_00);
    iresp = 1;
    tick("imiss_release", 9'b11111_00_10);
    clear_in();

    // I-miss and D-miss overlap, D finishes first
    iread = 1; exc.mem_read = 1;
    tick("both_wait0", 9'b00000_00_00);
    tick("both_wait1", 9'b00000_00_00);
    dresp = 1;
    tick("both_dcap", 9'b00000_00_01);
    dresp = 0;
    tick("both_wait3", 9'b00000_00_00);
    tick("both_wait4", 9'b00000_00_00);
    iresp = 1;
    tick("both_release", 9'b11111_00_10);
    clear_in();

    // Redirect held off by a three-cycle D-miss
    br = 1; exc.mem_write = 1;
    tick("br_held0", 9'b00000_00_00);
    tick("br_held1", 9'b00000_00_00);
    dresp = 1;
    tick("br_release", 9'b11111_11_01);
    clear_in();

    // Both responses on the same final cycle
    iread = 1; exc.mem_read = 1;
    tick("simul_wait", 9'b00000_00_00);
    iresp = 1; dresp = 1;
    tick("simul_release", 9'b11111_00_11);
    clear_in();

    // Reset during a wait discards the collected D response
    iread = 1; exc.mem_read = 1;
    tick("abandon_wait", 9'b00000_00_00);
    dresp = 1;
    tick("abandon_dcap", 9'b00000_00_01);
    dresp = 0; rst = 1;
    tick("abandon_reset", 9'b00000_11_00);
    rst = 0;
    tick("abandon_restart", 9'b00000_00_00);
    iresp = 1;
    tick("abandon_icap", 9'b00000_00_10);
    iresp = 0; dresp = 1;
    tick("abandon_release", 9'b11111_00_01);
    clear_in();

`ifdef HAZARD_PERF_CNT_EN
    rst = 1;
    tick("cnt_reset", 9'b00000_11_00);
    rst = 0; br = 1; idc.mem_read = 1; idc.load_regfile = 1; rd = 5; rs1 = 5;
    tick("cnt_br_lu", 9'b11111_11_00);
    clear_in();
    checks++;
    if (flush_cnt !== 32'd1) begin
      errors++;
      $display("FAIL flush_cnt: got %0d expected 1", flush_cnt);
    end
    checks++;
    if (stall_lu_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stall_lu_cnt: got %0d expected 0", stall_lu_cnt);
    end
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 39) == 0);
      rs1   = 5'($urandom_range(0, 3));
      rs2   = 5'($urandom_range(0, 3));
      rd    = 5'($urandom_range(0, 3));
      idc   = 3'($urandom_range(0, 7));
      exc   = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : '0;
      br    = ($urandom_range(0, 4) == 0);
      iread = ($urandom_range(0, 1) == 1);
      iresp = ($urandom_range(0, 3) == 0);
      dresp = ($urandom_range(0, 3) == 0);
      tick("random", model_out());
    end
    clear_in();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
